serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to add a and b; accepted only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH, first operand, sampled only on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH, second operand, sampled only on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1, high while a bit-serial addition is in progress.
REQ-008 The block SHALL have port done, output, 1, single-cycle pulse marking a new valid result.
REQ-009 The block SHALL have port sum, output, WIDTH, registered result of a+b modulo 2^WIDTH.
REQ-010 The block SHALL have port carry_out, output, 1, registered carry out of the MSB.

Function
REQ-011 The block SHALL implement states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL load a and b into shift registers, clear the carry flop and bit counter, and enter RUN.
REQ-013 In RUN, the block SHALL add operand LSBs and the carry flop in one 1-bit full-add per cycle, shift the sum bit into a working register from the MSB side, shift operands right, store the new carry, and increment the counter.
REQ-014 RUN SHALL last exactly WIDTH cycles; after the WIDTH-th bit it SHALL enter DONE.
REQ-015 On entering DONE, the block SHALL copy the working register to sum and the final carry to carry_out.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-018 Latency SHALL be fixed: start accepted at edge k means busy is high in cycles k+1..k+WIDTH and done is high in cycle k+WIDTH+1.
REQ-019 sum and carry_out SHALL hold the previous result during RUN and change only on entry to DONE.
REQ-020 start SHALL be ignored in RUN and DONE, with no queueing; changes to a or b after acceptance SHALL have no effect.
REQ-021 Overflow SHALL wrap: sum = (a+b) mod 2^WIDTH, carry_out = bit WIDTH of a+b.
REQ-022 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL set state to IDLE and busy, done, sum, carry_out, the carry flop, the counter and the shift registers to 0, regardless of state.
REQ-024 A reset during RUN SHALL abort the operation with no done pulse; sum and carry_out SHALL read 0 afterwards.
REQ-025 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-026 Shared package serial_adder_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-027 The 1-bit add SHALL be one combinational sub-module instance, full_adder (inputs a, b, cin; outputs sum, cout).

Verification
REQ-028 WIDTH=8, rst for 2 cycles -> busy=0, done=0, sum=0x00, carry_out=0.
REQ-029 start with a=0x00, b=0x00 -> busy high for 8 cycles, done pulses in cycle 9, sum=0x00, carry_out=0.
REQ-030 a=0xA5, b=0x5A -> sum=0xFF, carry_out=0; a=0xFF, b=0x01 -> sum=0x00, carry_out=1.
REQ-031 start with a=0x0F, b=0x01, then start with a=0xFF, b=0xFF in cycle 3 of RUN -> second request ignored, result 0x10 with carry 0, exactly one done pulse.
REQ-032 rst asserted in cycle 4 of RUN -> IDLE next cycle, no done pulse, sum=0x00; next start with a=0x80, b=0x80 -> sum=0x00, carry_out=1.
REQ-033 start held high continuously -> back-to-back operations every WIDTH+2 cycles, each producing exactly one done pulse.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding
// and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // IDLE waits for start, RUN processes one bit per cycle, DONE is the
    // single result-valid cycle before returning to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder used once per cycle by the serial
// datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Classic sum/majority formulation.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. On an accepted start, operands are captured
// into shift registers and added LSB-first, one full-add per cycle, over
// exactly WIDTH cycles. The result registers (sum, carry_out) only change
// when the FSM enters DONE, so they keep the previous result during RUN.
//
// Handshake: start is a request that is taken only when the FSM is in IDLE
// (and not in reset); there is no queueing, so a start seen in RUN or DONE
// is simply dropped. done is a one-cycle pulse when a new result is valid;
// busy is high for every RUN cycle. Operands are sampled only at the
// accepting edge.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output state_t           o_dbg_state
);

    // One extra bit over what is needed to count WIDTH-1, so the counter
    // never wraps inside an operation.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_carry_out;
    logic [CW-1:0]    r_cnt;

    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_work_next;

    // The one-bit add for the current LSB position.
    full_adder u_full_adder (
        .a    (r_op_a[0]),
        .b    (r_op_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // Sum bits enter from the MSB side so after WIDTH shifts the first
    // (LSB) result bit has reached bit 0.
    assign w_work_next = {w_fa_sum, r_work[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_shift = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_last       = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry flop, working register and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_op_a  <= a;
            r_op_b  <= b;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_op_a  <= r_op_a >> 1;
            r_op_b  <= r_op_b >> 1;
            r_work  <= w_work_next;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Result registers: loaded with the completed word on the edge that
    // enters DONE, otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else if (w_last) begin
            r_sum       <= w_work_next;
            r_carry_out <= w_fa_cout;
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign sum         = r_sum;
    assign carry_out   = r_carry_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8: expected results are queued when
// an operation is accepted and checked by a monitor when done pulses.
module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  logic [W:0] exp_q[$];
  logic [W:0] last_res = '0;
  logic [W:0] mon_exp;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .carry_out   (carry_out),
    .o_dbg_state (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got sum=%h carry=%b required no done", sum, carry_out);
      end else begin
        mon_exp  = exp_q.pop_front();
        last_res = mon_exp;
        if ({carry_out, sum} !== mon_exp) begin
          errors++;
          $display("FAIL result got carry=%b sum=%h required carry=%b sum=%h",
                   carry_out, sum, mon_exp[W], mon_exp[W-1:0]);
        end
      end
    end
  end

  // Watch one operation from the cycle after acceptance through DONE.
  // inject_cyc != 0 raises start (with all-ones operands) in that RUN cycle.
  task automatic wait_op(input int inject_cyc);
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      @(negedge clk);
      checks++;
      if (busy !== (cyc <= W)) begin
        errors++;
        $display("FAIL busy_window cyc=%0d got %b required %b", cyc, busy, (cyc <= W));
      end
      checks++;
      if (done !== (cyc == W + 1)) begin
        errors++;
        $display("FAIL done_window cyc=%0d got %b required %b", cyc, done, (cyc == W + 1));
      end
      if (cyc <= W) begin
        checks++;
        if ({carry_out, sum} !== last_res) begin
          errors++;
          $display("FAIL result_hold cyc=%0d got %h required %h", cyc, {carry_out, sum}, last_res);
        end
      end
      if (inject_cyc != 0) begin
        start = (cyc == inject_cyc);
        if (cyc == inject_cyc) begin
          a = 8'hFF;
          b = 8'hFF;
        end
      end
    end
    start = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge in IDLE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int inject_cyc);
    a     = ta;
    b     = tb;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back({1'b0, ta} + {1'b0, tb});
    #1;
    start = 1'b0;
    a     = W'($urandom_range(0, 255));
    b     = W'($urandom_range(0, 255));
    wait_op(inject_cyc);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL back_to_idle got busy=%b done=%b state=%0d required 0 0 0", busy, done, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b sum=%h carry=%b required 0 0 00 0",
               busy, done, sum, carry_out);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL start_during_reset got busy=%b state=%0d required 0 IDLE", busy, dbg_state);
    end
    last_res = '0;
  endtask

  task automatic test_basic();
    run_op(8'h00, 8'h00, 0);
    run_op(8'hA5, 8'h5A, 0);
    run_op(8'hFF, 8'h01, 0);
    run_op(8'hFF, 8'hFF, 0);
    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 0);
    end
  endtask

  task automatic test_ignore_start();
    int d0;
    d0 = n_done;
    run_op(8'h0F, 8'h01, 3);
    repeat (W + 3) @(negedge clk);
    checks++;
    if (n_done - d0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start got dones=%0d busy=%b required 1 0", n_done - d0, busy);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    a     = 8'h12;
    b     = 8'h34;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back({1'b0, 8'h12} + {1'b0, 8'h34});
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    last_res = '0;
    d0 = n_done;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL abort_state got busy=%b done=%b sum=%h carry=%b state=%0d required 0 0 00 0 IDLE",
               busy, done, sum, carry_out, dbg_state);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (n_done !== d0) begin
      errors++;
      $display("FAIL abort_no_done got %0d dones required 0", n_done - d0);
    end
    run_op(8'h80, 8'h80, 0);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0    = n_done;
    start = 1'b1;
    a     = W'($urandom_range(0, 255));
    b     = W'($urandom_range(0, 255));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      exp_q.push_back({1'b0, a} + {1'b0, b});
      #1;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      for (int cyc = 1; cyc <= W + 1; cyc++) begin
        @(negedge clk);
        checks++;
        if (done !== (cyc == W + 1) || busy !== (cyc <= W)) begin
          errors++;
          $display("FAIL b2b_timing op=%0d cyc=%0d got busy=%b done=%b", k, cyc, busy, done);
        end
      end
      @(posedge clk);
      if (k == 3) begin
        #1;
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_done - d0 !== 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count got dones=%0d busy=%b required 4 0", n_done - d0, busy);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
